// File: rtl/e_fwd_ctrl_pkg.sv
// Shared encodings for the E-stage hazard/forwarding controller:
// forwarding-select codes, result-source encodings and the "operand unused" Tuse.
package e_fwd_ctrl_pkg;

    localparam logic [2:0] FW_PC8   = 3'b000;
    localparam logic [2:0] FW_ALU_M = 3'b001;
    localparam logic [2:0] FW_MD_M  = 3'b010;
    localparam logic [2:0] FW_W     = 3'b011;
    localparam logic [2:0] FW_RF    = 3'b100;

    typedef enum logic [1:0] {
        SRC_LINK = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MD   = 2'd2,
        SRC_LOAD = 2'd3
    } src_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/e_fwd_ctrl_fwd_sel.sv
// Forwarding-select code for one E-stage operand, chosen from the M and W
// shadow destinations. Instantiated once per source operand.
module fwd_sel
    import e_fwd_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] idx,
    input  logic [REG_W-1:0] wa_M,
    input  logic [1:0]       tnew_M,
    input  src_e             src_M,
    input  logic [REG_W-1:0] wa_W,
    output logic [2:0]       fsel
);

    // M wins over W; a load still in M has no data on the M-stage buses yet.
    always_comb begin
        fsel = FW_RF;
        if (idx == '0) begin
            fsel = FW_RF;
        end else if (idx == wa_M && tnew_M == 2'd0 && src_M != SRC_LOAD) begin
            case (src_M)
                SRC_LINK: fsel = FW_PC8;
                SRC_ALU:  fsel = FW_ALU_M;
                SRC_MD:   fsel = FW_MD_M;
                default:  fsel = FW_RF;
            endcase
        end else if (idx == wa_W) begin
            fsel = FW_W;
        end
    end

endmodule

// File: rtl/e_fwd_ctrl.sv
// Hazard and forwarding controller: shadow E/M/W pipeline of destination, Tnew
// and result source, E-stage forwarding selects, and the D-stage stall/bubble.
module e_fwd_ctrl
    import e_fwd_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [REG_W-1:0] wa_D,
    input  logic [1:0]       tnew_D,
    input  logic [1:0]       src_D,
    input  logic             md_D,
    input  logic             mdu_start_E,
    input  logic             mdu_busy,
    input  logic             flush,
    output logic [2:0]       FSel1_E,
    output logic [2:0]       FSel2_E,
    output logic             stall,
    output logic             bubble_E
);

    logic [REG_W-1:0] rs_E, rt_E, wa_E, wa_M, wa_W;
    logic [1:0]       tnew_E, tnew_M;
    src_e             src_E, src_M;
    logic             stall_rs, stall_rt, stall_md;

    // Tnew counts down once per stage and sticks at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic reg_stall(
        input logic [REG_W-1:0] idx,
        input logic [1:0]       tuse,
        input logic [REG_W-1:0] wa_e,
        input logic [1:0]       tnew_e,
        input logic [REG_W-1:0] wa_m,
        input logic [1:0]       tnew_m
    );
        logic hit_e, hit_m;
        hit_e = (idx == wa_e) && (tuse < tnew_e);
        hit_m = (idx == wa_m) && (tuse < tnew_m);
        return (idx != '0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

    always_comb begin
        stall_rs = reg_stall(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M);
        stall_rt = reg_stall(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
        stall_md = md_D && (mdu_busy || mdu_start_E);
        stall    = stall_rs || stall_rt || stall_md;
        bubble_E = stall || flush;
    end

    fwd_sel #(.REG_W(REG_W)) u_sel_rs (
        .idx    (rs_E),
        .wa_M   (wa_M),
        .tnew_M (tnew_M),
        .src_M  (src_M),
        .wa_W   (wa_W),
        .fsel   (FSel1_E)
    );

    fwd_sel #(.REG_W(REG_W)) u_sel_rt (
        .idx    (rt_E),
        .wa_M   (wa_M),
        .tnew_M (tnew_M),
        .src_M  (src_M),
        .wa_W   (wa_W),
        .fsel   (FSel2_E)
    );

    // D -> E -> M -> W shadow pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_E   <= '0;
            rt_E   <= '0;
            wa_E   <= '0;
            tnew_E <= 2'd0;
            src_E  <= SRC_LINK;
            wa_M   <= '0;
            tnew_M <= 2'd0;
            src_M  <= SRC_LINK;
            wa_W   <= '0;
        end else begin
            wa_W <= wa_M;

            if (flush) begin
                wa_M   <= '0;
                tnew_M <= 2'd0;
                src_M  <= SRC_LINK;
            end else begin
                wa_M   <= wa_E;
                tnew_M <= tnew_dec(tnew_E);
                src_M  <= src_E;
            end

            if (bubble_E) begin
                rs_E   <= '0;
                rt_E   <= '0;
                wa_E   <= '0;
                tnew_E <= 2'd0;
                src_E  <= SRC_LINK;
            end else begin
                rs_E   <= rs_D;
                rt_E   <= rt_D;
                wa_E   <= wa_D;
                tnew_E <= tnew_D;
                src_E  <= src_e'(src_D);
            end
        end
    end

endmodule

// File: tb/tb_e_fwd_ctrl.sv
// Directed bench for e_fwd_ctrl: a per-cycle vector table of D-stage inputs with
// hand-computed outputs, followed by MDU, flush and reset-mid-stall sequences.
module tb_e_fwd_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D, rt_D, wa_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
    logic       md_D, mdu_start_E, mdu_busy, flush;
    logic [2:0] FSel1_E, FSel2_E;
    logic       stall, bubble_E;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, wa;
        logic [1:0] trs, trt, tnew, src;
        logic       md, start, busy, fl;
        logic [2:0] f1, f2;
        logic       st, bu;
    } vec_t;

    vec_t vecs[$];

    e_fwd_ctrl #(.REG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .wa_D        (wa_D),
        .tnew_D      (tnew_D),
        .src_D       (src_D),
        .md_D        (md_D),
        .mdu_start_E (mdu_start_E),
        .mdu_busy    (mdu_busy),
        .flush       (flush),
        .FSel1_E     (FSel1_E),
        .FSel2_E     (FSel2_E),
        .stall       (stall),
        .bubble_E    (bubble_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string nm, int rs, int trs, int rt, int trt, int wa,
                                int tn, int src, int f1, int f2, int st, int bu);
        vec_t v;
        v.name = nm;
        v.rs = rs[4:0];   v.trs = trs[1:0];
        v.rt = rt[4:0];   v.trt = trt[1:0];
        v.wa = wa[4:0];   v.tnew = tn[1:0];  v.src = src[1:0];
        v.md = 1'b0;      v.start = 1'b0;    v.busy = 1'b0;  v.fl = 1'b0;
        v.f1 = f1[2:0];   v.f2 = f2[2:0];
        v.st = st[0];     v.bu = bu[0];
        return v;
    endfunction

    function automatic vec_t nop(string nm, int f1, int f2, int st, int bu);
        return mk(nm, 0, 3, 0, 3, 0, 0, 0, f1, f2, st, bu);
    endfunction

    task automatic apply(input vec_t v);
        rs_D = v.rs;  tuse_rs_D = v.trs;
        rt_D = v.rt;  tuse_rt_D = v.trt;
        wa_D = v.wa;  tnew_D = v.tnew;  src_D = v.src;
        md_D = v.md;  mdu_start_E = v.start;  mdu_busy = v.busy;  flush = v.fl;
    endtask

    task automatic check(input string nm, input logic [2:0] f1, input logic [2:0] f2,
                         input logic st, input logic bu);
        total += 4;
        if (FSel1_E !== f1) begin
            bad++;
            $display("FAIL %s FSel1_E got=%b want=%b", nm, FSel1_E, f1);
        end
        if (FSel2_E !== f2) begin
            bad++;
            $display("FAIL %s FSel2_E got=%b want=%b", nm, FSel2_E, f2);
        end
        if (stall !== st) begin
            bad++;
            $display("FAIL %s stall got=%b want=%b", nm, stall, st);
        end
        if (bubble_E !== bu) begin
            bad++;
            $display("FAIL %s bubble_E got=%b want=%b", nm, bubble_E, bu);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // ALU producer, immediate consumer (tuse 1, no stall, forward from M)
        vecs.push_back(mk ("a_prod",   0, 3, 0, 3,  8, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk ("a_cons",   8, 1, 2, 1, 10, 1, 1, 4, 4, 0, 0));
        vecs.push_back(nop("a_fwd_m",                        1, 4, 0, 0));
        vecs.push_back(nop("a_nop",                          4, 4, 0, 0));
        // ALU producer, consumer two cycles later (forward from W)
        vecs.push_back(mk ("b_prod",   0, 3, 0, 3, 11, 1, 1, 4, 4, 0, 0));
        vecs.push_back(nop("b_gap",                          4, 4, 0, 0));
        vecs.push_back(mk ("b_cons",  11, 1,11, 1,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(nop("b_fwd_w",                        3, 3, 0, 0));
        // load-use with tuse 1: one-cycle stall, then W forward
        vecs.push_back(mk ("c_load",   0, 3, 0, 3,  9, 2, 3, 4, 4, 0, 0));
        vecs.push_back(mk ("c_use",    9, 1, 0, 3, 12, 1, 1, 4, 4, 1, 1));
        vecs.push_back(mk ("c_use_2",  9, 1, 0, 3, 12, 1, 1, 4, 4, 0, 0));
        vecs.push_back(nop("c_fwd_w",                        3, 4, 0, 0));
        // load result in M with tnew 0 is never taken from the M buses
        vecs.push_back(mk ("d_load1",  0, 3, 0, 3, 13, 1, 3, 4, 4, 0, 0));
        vecs.push_back(mk ("d_use",   13, 1, 0, 3,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(nop("d_nofwd",                        4, 4, 0, 0));
        // load-use with tuse 0: tnew - tuse = 2 stall cycles
        vecs.push_back(mk ("e_load",   0, 3, 0, 3, 14, 2, 3, 4, 4, 0, 0));
        vecs.push_back(mk ("e_use",   14, 0, 0, 3,  0, 0, 0, 4, 4, 1, 1));
        vecs.push_back(mk ("e_use_2", 14, 0, 0, 3,  0, 0, 0, 4, 4, 1, 1));
        vecs.push_back(mk ("e_use_3", 14, 0, 0, 3,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(nop("e_after",                        4, 4, 0, 0));
        // jal link forwarding; tnew 0 must stay 0 through M
        vecs.push_back(mk ("l_jal",    0, 3, 0, 3, 31, 0, 0, 4, 4, 0, 0));
        vecs.push_back(mk ("l_use",   31, 1,31, 1,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(nop("l_fwd",                          0, 0, 0, 0));
        // same register in M (MD source) and W (ALU): M has priority
        vecs.push_back(mk ("p_alu",    0, 3, 0, 3, 16, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk ("p_md",     0, 3, 0, 3, 16, 1, 2, 4, 4, 0, 0));
        vecs.push_back(mk ("p_use",   16, 1, 0, 3,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(nop("p_fwd",                          2, 4, 0, 0));
        // unused operand never stalls; rt stall against a load in M
        vecs.push_back(mk ("r_load",   0, 3, 0, 3, 15, 2, 3, 4, 4, 0, 0));
        vecs.push_back(mk ("r_none",  15, 3, 0, 3,  0, 0, 0, 4, 4, 0, 0));
        vecs.push_back(mk ("r_rt",     0, 3,15, 0,  0, 0, 0, 4, 4, 1, 1));
        vecs.push_back(mk ("r_rt_2",   0, 3,15, 0,  0, 0, 0, 4, 4, 0, 0));
        // $0 is never a hazard and never forwarded
        vecs.push_back(mk ("z_w0",     0, 3, 0, 3,  0, 2, 3, 4, 4, 0, 0));
        vecs.push_back(mk ("z_r0",     0, 0, 0, 0,  0, 0, 1, 4, 4, 0, 0));
        vecs.push_back(nop("z_fwd",                          4, 4, 0, 0));

        // reset with a self-dependent D instruction on the inputs
        v = mk("rst", 5, 0, 5, 0, 5, 2, 3, 4, 4, 0, 0);
        apply(v);
        reset = 1'b1;
        tick();
        #2 check("rst_during_1", 3'b100, 3'b100, 1'b0, 1'b0);
        tick();
        #2 check("rst_during_2", 3'b100, 3'b100, 1'b0, 1'b0);
        reset = 1'b0;
        #1 check("rst_after", 3'b100, 3'b100, 1'b0, 1'b0);
        apply(nop("idle", 4, 4, 0, 0));
        tick();
        tick();
        // the nop cycles above flushed the rst instruction through E/M

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #2 check(vecs[i].name, vecs[i].f1, vecs[i].f2, vecs[i].st, vecs[i].bu);
            tick();
        end
        apply(nop("idle", 4, 4, 0, 0));
        tick();
        tick();
        tick();

        // MDU: mult starting in E, mfhi in D, then 5 busy cycles
        v = nop("mdu", 4, 4, 1, 1);
        v.md = 1'b1;
        v.start = 1'b1;
        apply(v);
        #2 check("mdu_start", 3'b100, 3'b100, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            v.start = 1'b0;
            v.busy = 1'b1;
            apply(v);
            #2 check($sformatf("mdu_busy_%0d", i), 3'b100, 3'b100, 1'b1, 1'b1);
            tick();
        end
        v.busy = 1'b0;
        apply(v);
        #2 check("mdu_done", 3'b100, 3'b100, 1'b0, 1'b0);
        v.md = 1'b0;
        v.busy = 1'b1;
        apply(v);
        #2 check("mdu_busy_no_md", 3'b100, 3'b100, 1'b0, 1'b0);
        tick();

        // flush during a load-use stall
        apply(mk("f_load", 0, 3, 0, 3, 9, 2, 3, 4, 4, 0, 0));
        #2 check("f_load", 3'b100, 3'b100, 1'b0, 1'b0);
        tick();
        v = mk("f_use", 9, 0, 0, 3, 0, 0, 0, 4, 4, 1, 1);
        v.fl = 1'b1;
        apply(v);
        #2 check("f_flush_stall", 3'b100, 3'b100, 1'b1, 1'b1);
        tick();
        v.fl = 1'b0;
        apply(v);
        #2 check("f_after_flush", 3'b100, 3'b100, 1'b0, 1'b0);
        v = nop("f_only", 4, 4, 0, 1);
        v.fl = 1'b1;
        apply(v);
        #2 check("f_flush_only", 3'b100, 3'b100, 1'b0, 1'b1);
        tick();

        // reset in the middle of a load-use stall
        apply(mk("x_load", 0, 3, 0, 3, 20, 2, 3, 4, 4, 0, 0));
        tick();
        v = mk("x_use", 20, 0, 20, 0, 0, 0, 0, 4, 4, 1, 1);
        apply(v);
        #2 check("x_stall", 3'b100, 3'b100, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("x_after_reset", 3'b100, 3'b100, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
